fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage LEGv8 pipeline: PC register, PC+4 adder, branch-target select, and the IF/ID pipeline register.
- Directly upstream of the hazard detection unit, which reads IF_IDRegRn/Rm from this block's instruction output.
- Consumes that unit's PCWrite/IF_IDWrite stall controls.
- Accepts branch redirect and flush from the MEM stage; inserts a NOP bubble on flush.

Parameters:
- N, 64, PC/address width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h8B1F03FF, instruction word placed in IF/ID on flush or reset (ADD XZR,XZR,XZR).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  1 = PC may update; 0 = hold PC (load-use stall).
- IF_IDWrite  in  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- PCSrc  in  1  1 = redirect PC to branch_target this cycle (branch taken in MEM).
- branch_target  in  N  redirect address.
- IF_IDFlush  in  1  1 = replace IF/ID contents with bubble.
- imem_addr  out  N  current PC, drives combinational instruction memory.
- imem_data  in  32  instruction word read at imem_addr (same cycle).
- IF_ID_pc  out  N  PC of the instruction held in IF/ID.
- IF_ID_instr  out  32  instruction held in IF/ID.
- IF_ID_valid  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high on port reset; asserting it forces state immediately, independent of clk.
- Reset values: PC = RESET_PC, so imem_addr = RESET_PC. IF_ID_pc = 0, IF_ID_instr = NOP_INSTR, IF_ID_valid = 0.
- imem_addr = PC combinationally; fetch latency is 1 cycle (fetched word appears at IF/ID outputs after the next edge).
- PC next-state priority, highest first:
  - PCSrc = 1: PC <= branch_target. Overrides PCWrite = 0, because a taken branch in MEM squashes the stalled younger instructions.
  - PCWrite = 1: PC <= PC + 4, modulo 2^N; wrap from 2^N-4 to 0 with no error.
  - Otherwise PC holds.
- IF/ID next-state priority, highest first:
  - IF_IDFlush = 1: IF_ID_instr <= NOP_INSTR, IF_ID_valid <= 0, IF_ID_pc <= PC. Flush overrides IF_IDWrite = 0.
  - IF_IDWrite = 1: IF_ID_instr <= imem_data, IF_ID_pc <= PC, IF_ID_valid <= 1.
  - Otherwise all three hold.
- Simultaneous PCSrc = 1 and IF_IDFlush = 1 (normal taken branch): next PC = branch_target, IF/ID = bubble; the instruction at branch_target appears in IF/ID one cycle later.
- Stall (PCWrite = 0, IF_IDWrite = 0) for k cycles: PC and IF/ID frozen for exactly k edges; the same instruction is presented on IF_ID_instr throughout.
- PCWrite = 1 with IF_IDWrite = 0 is legal: PC advances, IF/ID holds. The skipped instruction is lost, which is the expected result of illegal hazard-unit combinations; no checking is done.
- Reset asserted mid-stall or mid-flush returns all state to reset values at once. The first fetch from RESET_PC appears in IF/ID on the first edge after reset deasserts.
- branch_target low 2 bits are used as given; no alignment enforcement.
- All flops are on clk with asynchronous reset; no combinational path from inputs to IF/ID outputs.

Optional Feature:
- Macro FETCH_STALL_COUNTER_EN.
- When defined:
  - Adds output port stall_count, 32 bits.
  - Counter increments on each clk edge where PCWrite = 0 and PCSrc = 0.
  - Saturates at 32'hFFFFFFFF; resets to 0 on reset.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: reset = 1, RESET_PC = 0x100 -> imem_addr = 0x100, IF_ID_valid = 0, IF_ID_instr = 0x8B1F03FF. Release reset, imem_data = 0xF8400020 -> after 1 edge IF_ID_instr = 0xF8400020, IF_ID_pc = 0x100, valid = 1, imem_addr = 0x104.
- Sequential fetch: 4 edges with PCWrite = IF_IDWrite = 1 from PC 0x0 -> imem_addr sequence 0x4, 0x8, 0xC, 0x10; IF_ID_pc lags by one.
- Load-use stall: PCWrite = IF_IDWrite = 0 for 2 edges at PC 0x20 -> imem_addr stays 0x20, IF/ID unchanged for 2 cycles, then resumes at 0x24. With macro defined, stall_count = 2.
- Taken branch: PCSrc = 1, IF_IDFlush = 1, branch_target = 0x400 while PCWrite = 0 -> next imem_addr = 0x400, IF_ID_valid = 0, IF_ID_instr = NOP; next edge IF_ID_pc = 0x400.
- Wrap: PC = 0xFFFFFFFFFFFFFFFC, PCWrite = 1 -> imem_addr = 0x0.
- Async reset mid-stall: assert reset between edges during stall -> outputs take reset values before next clk edge; stall_count = 0.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: PC register, PC+4 / branch-target select and the IF/ID pipeline register.
// Define FETCH_STALL_COUNTER_EN to add the saturating stall_count output.
module fetch_stage #(
    parameter int          N         = 64,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCWrite,
    input  logic         IF_IDWrite,
    input  logic         PCSrc,
    input  logic [N-1:0] branch_target,
    input  logic         IF_IDFlush,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_data,
    output logic [N-1:0] IF_ID_pc,
    output logic [31:0]  IF_ID_instr,
`ifdef FETCH_STALL_COUNTER_EN
    output logic         IF_ID_valid,
    output logic [31:0]  stall_count
`else
    output logic         IF_ID_valid
`endif
);

    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_pc_next;
    logic [N-1:0] r_if_id_pc;
    logic [31:0]  r_if_id_instr;
    logic         r_if_id_valid;

    // Adder wraps naturally modulo 2^N.
    assign w_pc_plus4 = r_pc + {{(N-3){1'b0}}, 3'd4};

    // A taken branch wins over a stall: the stalled younger instructions are being squashed anyway.
    always_comb begin
        w_pc_next = r_pc;
        if (PCSrc)
            w_pc_next = branch_target;
        else if (PCWrite)
            w_pc_next = w_pc_plus4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (IF_IDFlush) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (IF_IDWrite) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= imem_data;
            r_if_id_valid <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign IF_ID_pc    = r_if_id_pc;
    assign IF_ID_instr = r_if_id_instr;
    assign IF_ID_valid = r_if_id_valid;

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_count <= '0;
        else if (!PCWrite && !PCSrc && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table replayed through a scoreboard queue, plus reset sequences.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] NOP    = 32'h8B1F03FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, IF_IDWrite, PCSrc, IF_IDFlush;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [63:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] stall_count;
    logic [31:0] exp_sc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.N(64), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .PCSrc(PCSrc),
        .branch_target(branch_target), .IF_IDFlush(IF_IDFlush),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr),
`ifdef FETCH_STALL_COUNTER_EN
        .IF_ID_valid(IF_ID_valid), .stall_count(stall_count)
`else
        .IF_ID_valid(IF_ID_valid)
`endif
    );

    typedef struct {
        logic        pw, iw, src, fl;
        logic [63:0] tgt;
        logic [31:0] data;
        logic [63:0] e_addr, e_pc;
        logic [31:0] e_instr;
        logic        e_v;
    } vec_t;

    vec_t vecs[19];
    vec_t sbq[$];

    function automatic vec_t mk(logic pw, logic iw, logic src, logic fl, logic [63:0] tgt,
                                logic [31:0] data, logic [63:0] e_addr, logic [63:0] e_pc,
                                logic [31:0] e_instr, logic e_v);
        vec_t v;
        v.pw = pw; v.iw = iw; v.src = src; v.fl = fl; v.tgt = tgt; v.data = data;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_v = e_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [63:0] e_addr, input logic [63:0] e_pc,
                              input logic [31:0] e_instr, input logic e_v);
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".IF_ID_pc"}, IF_ID_pc, e_pc);
        check({tag, ".IF_ID_instr"}, {32'h0, IF_ID_instr}, {32'h0, e_instr});
        check({tag, ".IF_ID_valid"}, {63'h0, IF_ID_valid}, {63'h0, e_v});
    endtask

    initial begin
        vec_t v;
        // pw iw src fl target data | addr ifpc instr valid
        vecs[0]  = mk(1,1,0,0, 64'h0,   32'hF8400020, 64'h104, 64'h100, 32'hF8400020, 1);
        vecs[1]  = mk(0,0,1,1, 64'h0,   32'h11111111, 64'h0,   64'h104, NOP,          0);
        vecs[2]  = mk(1,1,0,0, 64'h0,   32'h000000A0, 64'h4,   64'h0,   32'h000000A0, 1);
        vecs[3]  = mk(1,1,0,0, 64'h0,   32'h000000A4, 64'h8,   64'h4,   32'h000000A4, 1);
        vecs[4]  = mk(1,1,0,0, 64'h0,   32'h000000A8, 64'hC,   64'h8,   32'h000000A8, 1);
        vecs[5]  = mk(1,1,0,0, 64'h0,   32'h000000AC, 64'h10,  64'hC,   32'h000000AC, 1);
        vecs[6]  = mk(1,1,1,0, 64'h20,  32'h000000B0, 64'h20,  64'h10,  32'h000000B0, 1);
        vecs[7]  = mk(0,0,0,0, 64'h0,   32'h000000C0, 64'h20,  64'h10,  32'h000000B0, 1);
        vecs[8]  = mk(0,0,0,0, 64'h0,   32'h000000C1, 64'h20,  64'h10,  32'h000000B0, 1);
        vecs[9]  = mk(1,1,0,0, 64'h0,   32'h000000C2, 64'h24,  64'h20,  32'h000000C2, 1);
        vecs[10] = mk(0,0,1,1, 64'h400, 32'h0000DEAD, 64'h400, 64'h24,  NOP,          0);
        vecs[11] = mk(1,1,0,0, 64'h0,   32'h000000E0, 64'h404, 64'h400, 32'h000000E0, 1);
        vecs[12] = mk(1,0,0,0, 64'h0,   32'h000000E1, 64'h408, 64'h400, 32'h000000E0, 1);
        vecs[13] = mk(0,1,0,0, 64'h0,   32'h000000E2, 64'h408, 64'h408, 32'h000000E2, 1);
        vecs[14] = mk(0,0,0,1, 64'h0,   32'h000000E3, 64'h408, 64'h408, NOP,          0);
        vecs[15] = mk(0,0,1,0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h408, NOP, 0);
        vecs[16] = mk(1,1,0,0, 64'h0,   32'h000000F0, 64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 32'h000000F0, 1);
        vecs[17] = mk(0,1,1,0, 64'h3,   32'h000000F1, 64'h3,   64'h0,   32'h000000F1, 1);
        vecs[18] = mk(1,1,0,0, 64'h0,   32'h000000F2, 64'h7,   64'h3,   32'h000000F2, 1);

        PCWrite = 0; IF_IDWrite = 0; PCSrc = 0; IF_IDFlush = 0;
        branch_target = '0; imem_data = 32'h0;
        reset = 1'b1;
        #12;
        check_ifid("reset", RST_PC, 64'h0, NOP, 1'b0);
`ifdef FETCH_STALL_COUNTER_EN
        exp_sc = 0;
        check("reset.stall_count", {32'h0, stall_count}, 64'h0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            PCWrite = vecs[i].pw; IF_IDWrite = vecs[i].iw; PCSrc = vecs[i].src;
            IF_IDFlush = vecs[i].fl; branch_target = vecs[i].tgt; imem_data = vecs[i].data;
            sbq.push_back(vecs[i]);
`ifdef FETCH_STALL_COUNTER_EN
            if (!vecs[i].pw && !vecs[i].src) exp_sc++;
`endif
            @(posedge clk); #1;
            v = sbq.pop_front();
            check_ifid($sformatf("vec%0d", i), v.e_addr, v.e_pc, v.e_instr, v.e_v);
`ifdef FETCH_STALL_COUNTER_EN
            check($sformatf("vec%0d.stall_count", i), {32'h0, stall_count}, {32'h0, exp_sc});
`endif
        end

        // Async reset during a stall: outputs must change before the next clock edge.
        PCWrite = 0; IF_IDWrite = 0; PCSrc = 0; IF_IDFlush = 0; imem_data = 32'h55555555;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_ifid("async_rst", RST_PC, 64'h0, NOP, 1'b0);
`ifdef FETCH_STALL_COUNTER_EN
        check("async_rst.stall_count", {32'h0, stall_count}, 64'h0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        PCWrite = 1; IF_IDWrite = 1; imem_data = 32'h12345678;
        @(posedge clk); #1;
        check_ifid("post_rst_fetch", RST_PC + 64'h4, RST_PC, 32'h12345678, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
